ps2_rx_fifo: RTL

Parametrised PS/2 device-to-host receiver with glitch filtering, frame timeout, parity/stop checking and an on-chip receive FIFO. It replaces the single-byte, PS/2-clock-domain keyboard decoder. Everything runs in the system `clk` domain, and validated scan codes are buffered for the CPU-side peripheral bus. The block is receive-only: it never drives the PS/2 lines, and the top level ties them to high-Z.

---
 rtl/ps2_rx_fifo.sv | 196 +++++++++++++++++++
 1 files changed

// File: rtl/ps2_rx_fifo.sv
// ps2_rx_fifo
// Receive-only PS/2 device-to-host decoder in the system clock domain.
// The raw PS/2 clock and data lines are synchronised, the clock is
// glitch-filtered, and 11-bit frames (start, 8 data LSB-first, odd parity,
// stop) are decoded. Good bytes go into a first-word-fall-through FIFO.
//
// Ports:
//   clk, rst          system clock, asynchronous active-high reset
//   ps2_clk, ps2_data raw PS/2 lines (asynchronous inputs)
//   rd_en             pop the FIFO head (ignored while empty)
//   rd_data           FIFO head, valid while !empty
//   empty, full       FIFO status
//   count             number of bytes held
//   parity_err        1-cycle pulse: frame dropped for bad parity
//   frame_err         1-cycle pulse: frame dropped for bad stop bit or timeout
//   overflow          1-cycle pulse: good byte dropped, FIFO full
module ps2_rx_fifo #(
  parameter int FILTER_CYCLES  = 16,
  parameter int TIMEOUT_CYCLES = 10000,
  parameter int FIFO_DEPTH     = 8,
  localparam int CW            = $clog2(FIFO_DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          ps2_clk,
  input  logic          ps2_data,
  input  logic          rd_en,
  output logic [7:0]    rd_data,
  output logic          empty,
  output logic          full,
  output logic [CW-1:0] count,
  output logic          parity_err,
  output logic          frame_err,
  output logic          overflow
);

  localparam int FW = (FILTER_CYCLES > 1) ? $clog2(FILTER_CYCLES) : 1;
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int AW = CW - 1;

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

  // ---------------- synchronisers (idle level of both lines is 1) --------
  logic clk_s1_reg, clk_s2_reg, dat_s1_reg, dat_s2_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      clk_s1_reg <= 1'b1;
      clk_s2_reg <= 1'b1;
      dat_s1_reg <= 1'b1;
      dat_s2_reg <= 1'b1;
    end else begin
      clk_s1_reg <= ps2_clk;
      clk_s2_reg <= clk_s1_reg;
      dat_s1_reg <= ps2_data;
      dat_s2_reg <= dat_s1_reg;
    end
  end

  // ---------------- clock glitch filter ----------------------------------
  // The counter tracks how long the synchronised clock has disagreed with
  // the filtered level; the level flips on the FILTER_CYCLES-th such cycle.
  logic          filt_clk_reg;
  logic [FW-1:0] filt_cnt_reg;
  logic          filt_flip;
  logic          fall;

  assign filt_flip = (clk_s2_reg != filt_clk_reg) &&
                     (filt_cnt_reg == FW'(FILTER_CYCLES - 1));
  assign fall      = filt_flip && filt_clk_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      filt_clk_reg <= 1'b1;
      filt_cnt_reg <= '0;
    end else if (clk_s2_reg == filt_clk_reg) begin
      filt_cnt_reg <= '0;
    end else if (filt_flip) begin
      filt_clk_reg <= clk_s2_reg;
      filt_cnt_reg <= '0;
    end else begin
      filt_cnt_reg <= filt_cnt_reg + 1'b1;
    end
  end

  // ---------------- FIFO status and handshake -----------------------------
  logic [CW-1:0] count_reg;
  logic          pop, push, accepting, timeout;
  state_t        state_reg;
  logic [7:0]    shift_reg;
  logic          par_ok_reg;

  assign empty     = (count_reg == '0);
  assign full      = (count_reg == CW'(FIFO_DEPTH));
  assign count     = count_reg;
  assign pop       = rd_en && !empty;
  assign accepting = !full || pop;
  assign push      = fall && (state_reg == STOP) && dat_s2_reg &&
                     par_ok_reg && accepting;

  // ---------------- frame state machine + timeout -------------------------
  logic [2:0]    bit_idx_reg;
  logic          acc_reg;
  logic [TW-1:0] to_cnt_reg;

  // A fall in the same cycle takes priority over the timeout.
  assign timeout = (state_reg != IDLE) && !fall &&
                   (to_cnt_reg == TW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg   <= IDLE;
      shift_reg   <= '0;
      bit_idx_reg <= '0;
      acc_reg     <= 1'b0;
      par_ok_reg  <= 1'b0;
      to_cnt_reg  <= '0;
      parity_err  <= 1'b0;
      frame_err   <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      overflow   <= 1'b0;
      if (fall) begin
        to_cnt_reg <= '0;
        case (state_reg)
          IDLE: begin
            // A high bit here is not a start bit: stay idle to resync.
            if (!dat_s2_reg) begin
              state_reg   <= DATA;
              shift_reg   <= '0;
              bit_idx_reg <= '0;
              acc_reg     <= 1'b0;
            end
          end
          DATA: begin
            shift_reg   <= {dat_s2_reg, shift_reg[7:1]};
            acc_reg     <= acc_reg ^ dat_s2_reg;
            bit_idx_reg <= bit_idx_reg + 3'd1;
            if (bit_idx_reg == 3'd7) state_reg <= PARITY;
          end
          PARITY: begin
            par_ok_reg <= acc_reg ^ dat_s2_reg;
            state_reg  <= STOP;
          end
          STOP: begin
            state_reg <= IDLE;
            if (!dat_s2_reg)      frame_err  <= 1'b1;
            else if (!par_ok_reg) parity_err <= 1'b1;
            else if (!accepting)  overflow   <= 1'b1;
          end
          default: state_reg <= IDLE;
        endcase
      end else if (timeout) begin
        state_reg  <= IDLE;
        frame_err  <= 1'b1;
        to_cnt_reg <= '0;
      end else if (state_reg != IDLE) begin
        to_cnt_reg <= to_cnt_reg + 1'b1;
      end
    end
  end

  // ---------------- FIFO storage ------------------------------------------
  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_reg, rd_ptr_reg;
  logic [7:0]    rd_data_reg;

  assign rd_data = rd_data_reg;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_reg] <= shift_reg;
  end

  // rd_data is a registered copy of the head so it has a defined reset
  // value; a byte written into an empty (or emptying) FIFO bypasses memory.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_reg  <= '0;
      rd_ptr_reg  <= '0;
      count_reg   <= '0;
      rd_data_reg <= '0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      if (push && !pop)      count_reg <= count_reg + 1'b1;
      else if (pop && !push) count_reg <= count_reg - 1'b1;
      if (push && (empty || (pop && count_reg == CW'(1))))
        rd_data_reg <= shift_reg;
      else if (pop)
        rd_data_reg <= mem[AW'(rd_ptr_reg + 1'b1)];
    end
  end

endmodule
